pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

- Central pipeline control sequencer for the 5-stage LoongArch32 core.
- Consumes stall/flush requests from the load-use hazard detector, the EX-stage branch unit and the data-memory handshake.
- Drives per-stage stall (hold) and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Tracks multi-cycle data-memory waits, flags memory timeouts, and optionally counts stall/flush events.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: wait cycles after which a pending memory access is flagged as timed out (1..65535).
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- stall_from_Load  in  1  load-use stall request from the hazard detector.
- flush_from_Load  in  1  load-use bubble request for ID/EX from the hazard detector.
- branch_taken_EX  in  1  taken branch/jump resolved in EX; younger instructions must be squashed.
- mem_req_MEM  in  1  MEM stage holds a valid load or store this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_PC  out  1  hold the PC.
- stall_IF_ID  out  1  hold IF/ID.
- flush_IF_ID  out  1  load a bubble into IF/ID.
- stall_ID_EX  out  1  hold ID/EX.
- flush_ID_EX  out  1  load a bubble into ID/EX.
- stall_EX_MEM  out  1  hold EX/MEM.
- flush_MEM_WB  out  1  load a bubble into MEM/WB.
- mem_wait  out  1  registered; FSM is in WAIT.
- mem_timeout  out  1  registered, sticky; a wait exceeded MEM_TIMEOUT cycles.
- stall_cnt  out  CNT_W  cycles with stall_PC high (only with PERF_CNT_EN).
- flush_cnt  out  CNT_W  branch flush events (only with PERF_CNT_EN).

## Operation
- FSM states: RUN, WAIT. Reset state: RUN.
- memhold = mem_req_MEM & ~mem_ready.

Transitions:
- RUN -> WAIT when memhold.
- WAIT -> RUN when mem_ready.
- WAIT holds while ~mem_ready.
- mem_req_MEM dropping in WAIT is a protocol violation: the FSM stays in WAIT until mem_ready.

Stage controls (combinational, same cycle as inputs), in priority order:
1. Memory hold: memhold, or WAIT & ~mem_ready.
   - stall_PC, stall_IF_ID, stall_ID_EX and stall_EX_MEM are high.
   - flush_MEM_WB is high.
   - Branch and load-use requests are ignored this cycle; they remain asserted because upstream is frozen.
2. Branch: branch_taken_EX.
   - flush_IF_ID and flush_ID_EX are high; all stalls are low.
   - A simultaneous load-use request is dropped, since the dependent instruction is squashed.
3. Load-use: stall_from_Load drives stall_PC and stall_IF_ID; flush_from_Load drives flush_ID_EX.
4. Otherwise all controls are low.

Invariants:
- A stage's stall and flush are never both high.
- stall_ID_EX and stall_EX_MEM are high only under memory hold.

Timeout:
- A 16-bit wait counter clears on entering WAIT and increments each WAIT cycle.
- mem_timeout sets when the counter reaches MEM_TIMEOUT while still waiting.
- mem_timeout stays set until reset.
- The counter saturates at MEM_TIMEOUT.

## Timing
- All stage controls have 0-cycle latency from their inputs.
- A mem_ready arriving in the same cycle as mem_req_MEM (single-cycle memory) causes no stall and no WAIT entry.
- mem_wait rises the cycle after the first memhold cycle and falls the cycle after mem_ready.
- Reset values: mem_wait=0, mem_timeout=0, wait counter=0, stall_cnt=0, flush_cnt=0.
- Reset is asynchronous mid-operation: the FSM returns to RUN immediately and combinational outputs follow the inputs.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with stall_PC=1.
  - flush_cnt increments on every cycle where branch_taken_EX wins (priority 2).
  - Both counters saturate at all-ones and do not wrap.
- PERF_CNT_EN undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

## Test plan
- Load-use only: stall_from_Load=1, flush_from_Load=1, others 0 -> stall_PC=1, stall_IF_ID=1, flush_ID_EX=1, all else 0; FSM stays RUN.
- Branch plus load-use in the same cycle -> flush_IF_ID=1, flush_ID_EX=1, stall_PC=0; flush_cnt +1 (PERF_CNT_EN).
- 3-cycle memory: mem_req_MEM=1, mem_ready=0 for 3 cycles then 1.
  - The four stalls and flush_MEM_WB are high for 3 cycles, then low.
  - mem_wait is high for cycles 2-4.
  - stall_cnt=3.
- Single-cycle memory: mem_req_MEM=1, mem_ready=1 -> no stall; mem_wait stays 0.
- Timeout with MEM_TIMEOUT=4 and mem_ready held 0 for 10 cycles -> mem_timeout rises after the 4th WAIT cycle and remains 1 after mem_ready.
- rstn pulsed low mid-WAIT -> mem_wait=0, mem_timeout=0 and counters 0 asynchronously; the FSM resumes in RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: memory-wait FSM, per-stage hold/bubble controls, memory timeout flag.
// Define PERF_CNT_EN to build the saturating stall/flush event counters; otherwise they read as zero.
module pipe_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall_from_Load,
   input  logic             flush_from_Load,
   input  logic             branch_taken_EX,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   output logic             stall_PC,
   output logic             stall_IF_ID,
   output logic             flush_IF_ID,
   output logic             stall_ID_EX,
   output logic             flush_ID_EX,
   output logic             stall_EX_MEM,
   output logic             flush_MEM_WB,
   output logic             mem_wait,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

   state_t      r_state, w_next;
   logic        w_memhold, w_hold;
   logic [15:0] r_wcnt;
   logic        r_timeout;

   always_comb begin
      w_memhold    = mem_req_MEM & ~mem_ready;
      w_hold       = w_memhold | ((r_state == S_WAIT) & ~mem_ready);
      w_next       = r_state;
      stall_PC     = 1'b0;
      stall_IF_ID  = 1'b0;
      flush_IF_ID  = 1'b0;
      stall_ID_EX  = 1'b0;
      flush_ID_EX  = 1'b0;
      stall_EX_MEM = 1'b0;
      flush_MEM_WB = 1'b0;
      case (r_state)
         S_RUN:   if (w_memhold) w_next = S_WAIT;
         S_WAIT:  if (mem_ready) w_next = S_RUN;
         default: w_next = S_RUN;
      endcase
      // Memory hold freezes everything upstream, so branch/load-use requests persist and are served later
      if (w_hold) begin
         stall_PC     = 1'b1;
         stall_IF_ID  = 1'b1;
         stall_ID_EX  = 1'b1;
         stall_EX_MEM = 1'b1;
         flush_MEM_WB = 1'b1;
      end else if (branch_taken_EX) begin
         flush_IF_ID  = 1'b1;
         flush_ID_EX  = 1'b1;
      end else begin
         stall_PC     = stall_from_Load;
         stall_IF_ID  = stall_from_Load;
         flush_ID_EX  = flush_from_Load;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_RUN;
         r_wcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_RUN && w_next == S_WAIT)
            r_wcnt <= '0;
         else if (r_state == S_WAIT && r_wcnt != TMO)
            r_wcnt <= r_wcnt + 16'd1;
         // Set when this WAIT cycle brings the count to the limit and the access is still outstanding
         if (r_state == S_WAIT && !mem_ready && r_wcnt >= TMO - 16'd1)
            r_timeout <= 1'b1;
      end
   end

   assign mem_wait    = (r_state == S_WAIT);
   assign mem_timeout = r_timeout;

`ifdef PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_flush_evt;

   assign w_flush_evt = branch_taken_EX & ~w_hold;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_PC && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         if (w_flush_evt && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan scenarios then randomized traffic vs. a behavioural model.
module tb_pipe_ctrl;

   localparam int unsigned MT = 4;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          sl = 1'b0, fl = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
   logic          stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, flush_MEM_WB;
   logic          mem_wait, mem_timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [6:0]    ctrl;

   always #5 clk = ~clk;

   pipe_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn),
      .stall_from_Load(sl), .flush_from_Load(fl), .branch_taken_EX(br),
      .mem_req_MEM(req), .mem_ready(rdy),
      .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
      .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX), .stall_EX_MEM(stall_EX_MEM),
      .flush_MEM_WB(flush_MEM_WB), .mem_wait(mem_wait), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign ctrl = {stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, flush_MEM_WB};

   int n_cmp = 0;
   int n_err = 0;

   // model state: outstanding access, cycles spent waiting, sticky timeout, event totals
   bit m_wait, m_tmo;
   int m_wcnt, m_scnt, m_fcnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit blocked();
      return (req && !rdy) || (m_wait && !rdy);
   endfunction

   // control vector order: stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, flush_MEM_WB
   function automatic logic [6:0] exp_ctrl();
      if (blocked())  return 7'b1101011;
      else if (br)    return 7'b0010100;
      else            return {sl, sl, 1'b0, 1'b0, fl, 1'b0, 1'b0};
   endfunction

   task automatic model_reset();
      m_wait = 0; m_tmo = 0; m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic model_clock();
      bit hold, pc_stalled, br_wins;
      hold       = blocked();
      br_wins    = !hold && br;
      pc_stalled = hold || (!br && sl);
      if (pc_stalled && m_scnt < (1 << CW) - 1) m_scnt++;
      if (br_wins && m_fcnt < (1 << CW) - 1) m_fcnt++;
      if (m_wait) begin
         if (m_wcnt < MT) m_wcnt++;
         if (!rdy && m_wcnt == MT) m_tmo = 1;
         m_wait = !rdy;
      end else if (req && !rdy) begin
         m_wait = 1;
         m_wcnt = 0;
      end
   endtask

   task automatic check_all();
      chk("ctrl", 32'(ctrl), 32'(exp_ctrl()));
      chk("mem_wait", 32'(mem_wait), 32'(m_wait));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
`ifdef PERF_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
`else
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
      chk("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
   endtask

   task automatic drive(input logic i_req, input logic i_rdy, input logic i_br, input logic i_sl, input logic i_fl);
      req = i_req; rdy = i_rdy; br = i_br; sl = i_sl; fl = i_fl;
      #1;
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rstn = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_all();
      chk("rst_wait", 32'(mem_wait), 32'd0);
      chk("rst_tmo", 32'(mem_timeout), 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // load-use only
      drive(0, 0, 0, 1, 1);
      chk("lu_ctrl", 32'(ctrl), 32'h64);
      tick();
      chk("lu_run", 32'(mem_wait), 32'd0);

      // branch wins over simultaneous load-use
      drive(0, 0, 1, 1, 1);
      chk("br_ctrl", 32'(ctrl), 32'h14);
      tick();
`ifdef PERF_CNT_EN
      chk("br_fcnt", 32'(flush_cnt), 32'd1);
`endif

      // 3-cycle memory
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 1, 1);
         chk("m3_ctrl", 32'(ctrl), 32'h6B);
         chk("m3_wait", 32'(mem_wait), (i > 0) ? 32'd1 : 32'd0);
         tick();
      end
      drive(1, 1, 0, 0, 0);
      chk("m3_done_ctrl", 32'(ctrl), 32'd0);
      chk("m3_done_wait", 32'(mem_wait), 32'd1);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("m3_after_wait", 32'(mem_wait), 32'd0);
`ifdef PERF_CNT_EN
      chk("m3_scnt", 32'(stall_cnt), 32'd3);
`endif

      // single-cycle memory
      drive(1, 1, 0, 0, 0);
      chk("m1_ctrl", 32'(ctrl), 32'd0);
      tick();
      chk("m1_wait", 32'(mem_wait), 32'd0);

      // timeout: entry cycle then 9 WAIT cycles; flag appears after the 4th WAIT cycle
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         drive(1, 0, 0, 0, 0);
         tick();
         chk("tmo_rise", 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
      end
      drive(1, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("tmo_sticky", 32'(mem_timeout), 32'd1);

      // asynchronous reset while waiting
      drive(1, 0, 0, 1, 0);
      tick();
      drive(1, 0, 0, 1, 0);
      tick();
      chk("ar_pre_wait", 32'(mem_wait), 32'd1);
      #2 rstn = 1'b0;
      model_reset();
      #1;
      chk("ar_wait", 32'(mem_wait), 32'd0);
      chk("ar_tmo", 32'(mem_timeout), 32'd0);
      chk("ar_ctrl", 32'(ctrl), 32'h6B);
      check_all();
      rdy = 1'b1;
      #1;
      chk("ar_ctrl_rdy", 32'(ctrl), 32'h60);
      @(negedge clk);
      rstn = 1'b1;
      drive(0, 0, 0, 0, 0);
      tick();
      chk("ar_resume", 32'(mem_wait), 32'd0);

      // randomized traffic, including req dropping mid-wait
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
         tick();
      end
      drive(0, 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
